// File: rtl/svpwm_pkg.sv
// Shared constants for the SVPWM chain: default widths, counter direction
// encoding and the sector numbering used by the sector/working-time stages.
package svpwm_pkg;

  localparam int CNT_W_DEF = 12;
  localparam int DT_W_DEF  = 8;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [2:0] {
    SECTOR_1 = 3'd1,
    SECTOR_2 = 3'd2,
    SECTOR_3 = 3'd3,
    SECTOR_4 = 3'd4,
    SECTOR_5 = 3'd5,
    SECTOR_6 = 3'd6
  } sector_e;

endpackage

// File: rtl/svpwm_center_pwm_dt_if.sv
// Control/compare inputs and gate/status outputs of the centre-aligned PWM stage.
interface svpwm_center_pwm_dt_if #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 12,
  parameter int DT_W  = 8
);

  logic                    iEnable;
  logic                    iLoad;
  logic [N_CH*CNT_W-1:0]   iCCR;
  logic [CNT_W-1:0]        iPeriod;
  logic [DT_W-1:0]         iDeadtime;
  logic [N_CH-1:0]         oPWM_H;
  logic [N_CH-1:0]         oPWM_L;
  logic [CNT_W-1:0]        oCount;
  logic                    oDirDown;
  logic                    oUpdate;
  logic                    oValley;

  modport master (
    output iEnable, iLoad, iCCR, iPeriod, iDeadtime,
    input  oPWM_H, oPWM_L, oCount, oDirDown, oUpdate, oValley
  );

  modport slave (
    input  iEnable, iLoad, iCCR, iPeriod, iDeadtime,
    output oPWM_H, oPWM_L, oCount, oDirDown, oUpdate, oValley
  );

endinterface

// File: rtl/svpwm_deadtime_ch.sv
// One complementary gate pair: a gate turns on only after the raw level has
// been stable for dt clocks; the opposite gate turns off at once.
module svpwm_deadtime_ch #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            raw,
  input  logic [DT_W-1:0] dt,
  output logic            pwm_h,
  output logic            pwm_l
);

  localparam logic [DT_W-1:0] RUN_ZERO = {DT_W{1'b0}};
  localparam logic [DT_W-1:0] RUN_ONE  = {{(DT_W-1){1'b0}}, 1'b1};
  localparam logic [DT_W-1:0] RUN_MAX  = {DT_W{1'b1}};

  logic [DT_W-1:0] run_q, run_d;
  logic            raw_prev_q, raw_prev_d;
  logic            live_q, live_d;
  logic            h_q, h_d;
  logic            l_q, l_d;

  // run_d = clocks the current raw level has already been held while enabled
  always_comb begin
    run_d      = RUN_ZERO;
    raw_prev_d = 1'b0;
    live_d     = 1'b0;
    h_d        = 1'b0;
    l_d        = 1'b0;
    if (en) begin
      if (live_q && (raw == raw_prev_q)) begin
        run_d = (run_q == RUN_MAX) ? run_q : (run_q + RUN_ONE);
      end else begin
        run_d = RUN_ZERO;
      end
      raw_prev_d = raw;
      live_d     = 1'b1;
      h_d        = raw && (run_d >= dt);
      l_d        = !raw && (run_d >= dt);
    end else begin
      run_d = RUN_ZERO;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q      <= RUN_ZERO;
      raw_prev_q <= 1'b0;
      live_q     <= 1'b0;
      h_q        <= 1'b0;
      l_q        <= 1'b0;
    end else begin
      run_q      <= run_d;
      raw_prev_q <= raw_prev_d;
      live_q     <= live_d;
      h_q        <= h_d;
      l_q        <= l_d;
    end
  end

  assign pwm_h = h_q;
  assign pwm_l = l_q;

endmodule

// File: rtl/svpwm_center_pwm_dt.sv
// Centre-aligned N-channel PWM: triangle counter, double-buffered compare/period/
// dead-time banks, and per-channel dead-time gate drivers.
module svpwm_center_pwm_dt
  import svpwm_pkg::*;
#(
  parameter int N_CH     = 3,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DT_W     = DT_W_DEF,
  parameter bit UPD_BOTH = 1'b0
) (
  input  logic                  iClk,
  input  logic                  iRst,
  svpwm_center_pwm_dt_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]            count_q, count_d;
  logic                        dir_q, dir_d;
  logic [N_CH-1:0][CNT_W-1:0]  act_ccr_q, act_ccr_d, sh_ccr_q, sh_ccr_d;
  logic [CNT_W-1:0]            act_period_q, act_period_d, sh_period_q, sh_period_d;
  logic [DT_W-1:0]             act_dt_q, act_dt_d, sh_dt_q, sh_dt_d;
  logic                        pending_q, pending_d;
  logic                        update_q, update_d;
  logic                        valley_q, valley_d;
  logic                        upd_evt_s, xfer_s;
  logic [CNT_W-1:0]            period_eff_s;
  logic [N_CH-1:0]             raw_s, pwm_h_s, pwm_l_s;

  // Update events and shadow/active bank transfer; a load in the transfer cycle
  // refills the shadow and keeps pending set.
  always_comb begin
    upd_evt_s    = bus.iEnable && ((count_q == CNT_ZERO) ||
                   (UPD_BOTH && (count_q == act_period_q)));
    xfer_s       = upd_evt_s && pending_q;
    period_eff_s = xfer_s ? sh_period_q : act_period_q;
    act_ccr_d    = act_ccr_q;
    act_period_d = act_period_q;
    act_dt_d     = act_dt_q;
    if (xfer_s) begin
      act_ccr_d    = sh_ccr_q;
      act_period_d = sh_period_q;
      act_dt_d     = sh_dt_q;
    end else begin
      act_ccr_d    = act_ccr_q;
    end
    sh_ccr_d    = sh_ccr_q;
    sh_period_d = sh_period_q;
    sh_dt_d     = sh_dt_q;
    pending_d   = pending_q;
    if (bus.iLoad) begin
      sh_ccr_d    = bus.iCCR;
      sh_period_d = bus.iPeriod;
      sh_dt_d     = bus.iDeadtime;
      pending_d   = 1'b1;
    end else if (xfer_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    update_d = xfer_s;
    valley_d = bus.iEnable && (count_q == CNT_ZERO);
  end

  // Triangle counter; the turn-around uses the period that is active next cycle
  always_comb begin
    count_d = CNT_ZERO;
    dir_d   = DIR_UP;
    if (!bus.iEnable || (period_eff_s == CNT_ZERO)) begin
      count_d = CNT_ZERO;
      dir_d   = DIR_UP;
    end else if ((dir_q == DIR_UP) && (count_q >= period_eff_s)) begin
      count_d = count_q - CNT_ONE;
      dir_d   = DIR_DOWN;
    end else if ((dir_q == DIR_DOWN) && (count_q != CNT_ZERO)) begin
      count_d = count_q - CNT_ONE;
      dir_d   = DIR_DOWN;
    end else begin
      count_d = count_q + CNT_ONE;
      dir_d   = DIR_UP;
    end
  end

  always_comb begin
    raw_s = {N_CH{1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      raw_s[k] = (count_q >= act_ccr_q[k]);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      count_q      <= CNT_ZERO;
      dir_q        <= DIR_UP;
      act_ccr_q    <= {(N_CH*CNT_W){1'b0}};
      sh_ccr_q     <= {(N_CH*CNT_W){1'b0}};
      act_period_q <= CNT_ZERO;
      sh_period_q  <= CNT_ZERO;
      act_dt_q     <= {DT_W{1'b0}};
      sh_dt_q      <= {DT_W{1'b0}};
      pending_q    <= 1'b0;
      update_q     <= 1'b0;
      valley_q     <= 1'b0;
    end else begin
      count_q      <= count_d;
      dir_q        <= dir_d;
      act_ccr_q    <= act_ccr_d;
      sh_ccr_q     <= sh_ccr_d;
      act_period_q <= act_period_d;
      sh_period_q  <= sh_period_d;
      act_dt_q     <= act_dt_d;
      sh_dt_q      <= sh_dt_d;
      pending_q    <= pending_d;
      update_q     <= update_d;
      valley_q     <= valley_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    svpwm_deadtime_ch #(.DT_W(DT_W)) u_dt (
      .clk   (iClk),
      .rst   (iRst),
      .en    (bus.iEnable),
      .raw   (raw_s[k]),
      .dt    (act_dt_q),
      .pwm_h (pwm_h_s[k]),
      .pwm_l (pwm_l_s[k])
    );
  end

  assign bus.oPWM_H   = pwm_h_s;
  assign bus.oPWM_L   = pwm_l_s;
  assign bus.oCount   = count_q;
  assign bus.oDirDown = dir_q;
  assign bus.oUpdate  = update_q;
  assign bus.oValley  = valley_q;

endmodule

// File: tb/tb_svpwm_center_pwm_dt.sv
// Drives a valley-only and a valley+peak update instance with identical stimulus
// and compares both against a history-based behavioural model every clock.
module tb_svpwm_center_pwm_dt;

  localparam int N_CH  = 3;
  localparam int CNT_W = 12;
  localparam int DT_W  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             en, ld;
  logic [CNT_W-1:0] ccr_v [3];
  logic [CNT_W-1:0] per_v;
  logic [DT_W-1:0]  dt_v;
  logic [N_CH*CNT_W-1:0] ccr_pk;
  assign ccr_pk = {ccr_v[2], ccr_v[1], ccr_v[0]};

  svpwm_center_pwm_dt_if #(.N_CH(N_CH), .CNT_W(CNT_W), .DT_W(DT_W)) bus0 ();
  svpwm_center_pwm_dt_if #(.N_CH(N_CH), .CNT_W(CNT_W), .DT_W(DT_W)) bus1 ();

  assign bus0.iEnable = en;     assign bus1.iEnable = en;
  assign bus0.iLoad = ld;       assign bus1.iLoad = ld;
  assign bus0.iCCR = ccr_pk;    assign bus1.iCCR = ccr_pk;
  assign bus0.iPeriod = per_v;  assign bus1.iPeriod = per_v;
  assign bus0.iDeadtime = dt_v; assign bus1.iDeadtime = dt_v;

  svpwm_center_pwm_dt #(.N_CH(N_CH), .CNT_W(CNT_W), .DT_W(DT_W), .UPD_BOTH(1'b0))
    u_dut0 (.iClk(clk), .iRst(rst), .bus(bus0));
  svpwm_center_pwm_dt #(.N_CH(N_CH), .CNT_W(CNT_W), .DT_W(DT_W), .UPD_BOTH(1'b1))
    u_dut1 (.iClk(clk), .iRst(rst), .bus(bus1));

  logic [20:0] obs_v [2];
  assign obs_v[0] = {bus0.oPWM_H, bus0.oPWM_L, bus0.oCount, bus0.oDirDown, bus0.oUpdate, bus0.oValley};
  assign obs_v[1] = {bus1.oPWM_H, bus1.oPWM_L, bus1.oCount, bus1.oDirDown, bus1.oUpdate, bus1.oValley};

  int checks = 0;
  int failures = 0;

  int m_cnt [2], a_p [2], a_dt [2], s_p [2], s_dt [2];
  int a_ccr [2][3], s_ccr [2][3];
  bit m_dir [2], pend [2], e_upd [2], e_val [2];
  bit e_h [2][3], e_l [2][3];
  bit hr [2][3][256];
  bit he [2][256];
  int tcur = 0;

  int hc [2][3], lc [2][3], nc [3], both_c, upd_c [2], val_c [2];
  int v_first, v_second, cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A gate is on when raw has been identical and enabled for the current and
  // previous dt cycles; a transfer copies shadow to active at valley/peak.
  task automatic model_step();
    bit raw, ok, ev, tr, go_down;
    int idx;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        m_cnt[u] = 0; m_dir[u] = 1'b0; a_p[u] = 0; a_dt[u] = 0; s_p[u] = 0; s_dt[u] = 0;
        pend[u] = 1'b0; e_upd[u] = 1'b0; e_val[u] = 1'b0; he[u][tcur] = 1'b0;
        for (int c = 0; c < 3; c++) begin
          a_ccr[u][c] = 0; s_ccr[u][c] = 0; e_h[u][c] = 1'b0; e_l[u][c] = 1'b0;
        end
      end else begin
        he[u][tcur] = en;
        for (int c = 0; c < 3; c++) begin
          raw = (m_cnt[u] >= a_ccr[u][c]);
          hr[u][c][tcur] = raw;
          ok = en;
          for (int i = 0; i <= a_dt[u]; i++) begin
            idx = (tcur - i + 256) % 256;
            if (!he[u][idx] || (hr[u][c][idx] != raw)) ok = 1'b0;
          end
          e_h[u][c] = ok && raw;
          e_l[u][c] = ok && !raw;
        end
        ev = en && ((m_cnt[u] == 0) || ((u == 1) && (m_cnt[u] == a_p[u])));
        tr = ev && pend[u];
        e_upd[u] = tr;
        e_val[u] = en && (m_cnt[u] == 0);
        if (tr) begin
          a_p[u] = s_p[u]; a_dt[u] = s_dt[u];
          for (int c = 0; c < 3; c++) a_ccr[u][c] = s_ccr[u][c];
        end
        if (ld) begin
          s_p[u] = int'(per_v); s_dt[u] = int'(dt_v); pend[u] = 1'b1;
          for (int c = 0; c < 3; c++) s_ccr[u][c] = int'(ccr_v[c]);
        end else if (tr) begin
          pend[u] = 1'b0;
        end
        go_down = (!m_dir[u] && (m_cnt[u] >= a_p[u])) || (m_dir[u] && (m_cnt[u] != 0));
        if (!en || (a_p[u] == 0)) begin
          m_cnt[u] = 0; m_dir[u] = 1'b0;
        end else if (go_down) begin
          m_cnt[u] = m_cnt[u] - 1; m_dir[u] = 1'b1;
        end else begin
          m_cnt[u] = m_cnt[u] + 1; m_dir[u] = 1'b0;
        end
      end
    end
    tcur = (tcur + 1) % 256;
  endtask

  task automatic step();
    logic [20:0] ev;
    model_step();
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      ev = {e_h[u][2], e_h[u][1], e_h[u][0], e_l[u][2], e_l[u][1], e_l[u][0],
            12'(m_cnt[u]), m_dir[u], e_upd[u], e_val[u]};
      chk((u == 0) ? "model_u0" : "model_u1", {11'd0, obs_v[u]}, {11'd0, ev});
    end
  endtask

  task automatic run_win(input int n);
    both_c = 0; v_first = -1; v_second = -1;
    for (int u = 0; u < 2; u++) begin
      upd_c[u] = 0; val_c[u] = 0;
      for (int c = 0; c < 3; c++) begin hc[u][c] = 0; lc[u][c] = 0; end
    end
    for (int c = 0; c < 3; c++) nc[c] = 0;
    for (int i = 0; i < n; i++) begin
      step();
      for (int c = 0; c < 3; c++) begin
        hc[0][c] += int'(bus0.oPWM_H[c]); lc[0][c] += int'(bus0.oPWM_L[c]);
        hc[1][c] += int'(bus1.oPWM_H[c]); lc[1][c] += int'(bus1.oPWM_L[c]);
        if (!bus0.oPWM_H[c] && !bus0.oPWM_L[c]) nc[c]++;
        if (bus0.oPWM_H[c] && bus0.oPWM_L[c]) both_c++;
      end
      upd_c[0] += int'(bus0.oUpdate); upd_c[1] += int'(bus1.oUpdate);
      val_c[0] += int'(bus0.oValley); val_c[1] += int'(bus1.oValley);
      if (bus0.oValley) begin
        if (v_first < 0) v_first = i;
        else if (v_second < 0) v_second = i;
      end
    end
  endtask

  task automatic wait_cnt(input string tag, input int tgt, input int want_dir);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if ((int'(bus0.oCount) == tgt) && ((want_dir < 0) || (int'(bus0.oDirDown) == want_dir)))
        found = 1'b1;
      else
        step();
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic load(input int p, input int c0, input int c1, input int c2, input int d);
    per_v = 12'(p); ccr_v[0] = 12'(c0); ccr_v[1] = 12'(c1); ccr_v[2] = 12'(c2); dt_v = 8'(d);
    ld = 1'b1;
    step();
    ld = 1'b0;
  endtask

  initial begin
    int p;
    rst = 1'b1; en = 1'b0; ld = 1'b0; per_v = 12'd0; dt_v = 8'd0;
    for (int c = 0; c < 3; c++) ccr_v[c] = 12'd0;
    step(); step();
    rst = 1'b0;
    chk("reset_count", {20'd0, bus0.oCount}, 32'd0);

    // triangle and compare, dt=0
    load(10, 4, 4, 4, 0);
    en = 1'b1;
    run_win(60);
    chk("first_update_once", upd_c[0], 32'd1);
    run_win(40);
    chk("tri_h_high", hc[0][0], 32'd26);
    chk("tri_l_high", lc[0][0], 32'd14);
    chk("valley_count", val_c[0], 32'd2);
    chk("valley_spacing", v_second - v_first, 32'd20);

    // dead time 2
    load(10, 4, 4, 4, 2);
    run_win(40);
    run_win(40);
    chk("dt_h_high", hc[0][0], 32'd22);
    chk("dt_l_high", lc[0][0], 32'd10);
    chk("dt_gap", nc[0], 32'd8);
    chk("dt_never_both", both_c, 32'd0);

    // shadow timing: valley-only vs valley+peak
    load(10, 4, 4, 4, 0);
    run_win(40);
    wait_cnt("wait_up2", 2, 0);
    load(10, 8, 8, 8, 0);
    wait_cnt("wait_up5", 5, 0);
    chk("sh_up_u0", {31'd0, bus0.oPWM_H[0]}, 32'd1);
    chk("sh_up_u1", {31'd0, bus1.oPWM_H[0]}, 32'd1);
    wait_cnt("wait_dn5", 5, 1);
    chk("sh_dn_u0_old", {31'd0, bus0.oPWM_H[0]}, 32'd1);
    chk("sh_dn_u1_new", {31'd0, bus1.oPWM_H[0]}, 32'd0);
    run_win(20);
    run_win(40);
    chk("sh_new_h_u0", hc[0][0], 32'd10);
    chk("sh_new_h_u1", hc[1][0], 32'd10);

    // boundaries
    load(10, 0, 11, 10, 3);
    run_win(40);
    run_win(40);
    chk("ccr0_h_const", hc[0][0], 32'd40);
    chk("ccr_over_h_zero", hc[0][1], 32'd0);
    chk("ccr_over_l_const", lc[0][1], 32'd40);
    chk("short_pulse_swallowed", hc[0][2], 32'd0);

    // collision: load exactly on the valley with pending set
    load(10, 4, 4, 4, 0);
    wait_cnt("wait_valley", 0, -1);
    load(10, 6, 6, 6, 0);
    chk("coll_old_applied", {31'd0, bus0.oUpdate}, 32'd1);
    run_win(19);
    chk("coll_no_early", upd_c[0], 32'd0);
    run_win(3);
    chk("coll_next_valley", upd_c[0], 32'd1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      en = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 15) == 0) begin
        p = $urandom_range(0, 20);
        per_v = 12'(p);
        for (int c = 0; c < 3; c++) ccr_v[c] = 12'($urandom_range(0, p + 2));
        dt_v = 8'($urandom_range(0, 4));
        ld = 1'b1;
      end else begin
        ld = 1'b0;
      end
      step();
    end
    ld = 1'b0; en = 1'b1;

    // reset mid-period with a pending load
    load(10, 4, 4, 4, 0);
    run_win(30);
    load(10, 7, 7, 7, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_h", {29'd0, bus0.oPWM_H}, 32'd0);
    chk("rst_l", {29'd0, bus0.oPWM_L}, 32'd0);
    chk("rst_cnt", {20'd0, bus0.oCount}, 32'd0);
    chk("rst_dir", {31'd0, bus0.oDirDown}, 32'd0);
    run_win(30);
    chk("rst_pending_cleared", upd_c[0], 32'd0);
    chk("p0_valley_every", val_c[0], 32'd30);
    chk("p0_h_const", hc[0][0], 32'd30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
